// File: rtl/xsw_pkg.sv
// Shared constants and types for the switch egress arbiter.
// Port count, field widths and the output-stage state encoding.
package xsw_pkg;

    localparam int unsigned NUM_PORTS     = 8;
    localparam int unsigned PORT_W        = 3;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/xsw_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester found searching circularly upward from ptr_i.
module xsw_rr_arbiter
    import xsw_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] gnt_oh_o,
    output logic [PORT_W-1:0]    gnt_idx_o,
    output logic                 gnt_any_o
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        idx       = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        // Walk from the farthest offset back to ptr so the nearest requester wins.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = ptr_i + PORT_W'(i);
            if (req_i[idx]) begin
                gnt_idx_o = idx;
                gnt_any_o = 1'b1;
            end
        end
        gnt_oh_o = gnt_any_o ? (NUM_PORTS'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/xsw_egress_arbiter.sv
// Drains per-port switch FIFOs round-robin into a single registered egress stage,
// counting accepted beats per source port.
module xsw_egress_arbiter
    import xsw_pkg::*;
#(
    parameter int unsigned NPORTS = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        data_rdy,
    input  logic [NPORTS*BYTE_W-1:0] addr_out,
    input  logic [NPORTS*BYTE_W-1:0] data_out,
    output logic [NPORTS-1:0]        rd_en,
    input  logic                     drain_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PORT_W-1:0]        out_port,
    output logic [BYTE_W-1:0]        out_addr,
    output logic [BYTE_W-1:0]        out_data,
    input  logic [PORT_W-1:0]        cnt_sel,
    output logic [CNT_W-1:0]         cnt_value,
    input  logic                     cnt_clr
);

    stage_state_e      state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d, rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0] addr_q, addr_d, data_q, data_d;
    logic [CNT_W-1:0]  cnt_q [NPORTS];
    logic [CNT_W-1:0]  cnt_d [NPORTS];
    logic [CNT_W-1:0]  cnt_value_q, cnt_value_d;

    logic [NPORTS-1:0] gnt_oh;
    logic [PORT_W-1:0] gnt_idx;
    logic              gnt_any;
    logic              stage_free, accept, pop;

    xsw_rr_arbiter u_rr_arbiter (
        .req_i     (data_rdy),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    always_comb begin
        stage_free = (state_q == StEmpty) || out_ready;
        accept     = (state_q == StFull) && out_ready;
        pop        = !reset && drain_en && stage_free && gnt_any;
        rd_en      = pop ? gnt_oh : '0;

        state_d  = state_q;
        port_d   = port_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            state_d  = StFull;
            port_d   = gnt_idx;
            addr_d   = addr_out[BYTE_W*gnt_idx +: BYTE_W];
            data_d   = data_out[BYTE_W*gnt_idx +: BYTE_W];
            rr_ptr_d = gnt_idx + PORT_W'(1);
        end else if (accept) begin
            state_d = StEmpty;
        end

        // Clear wins over a same-cycle increment; counters saturate at all-ones.
        for (int i = 0; i < NPORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (accept && (port_q == PORT_W'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        cnt_value_d = cnt_q[cnt_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            port_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rr_ptr_q    <= '0;
            cnt_value_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_value_q <= cnt_value_d;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_port  = port_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign cnt_value = cnt_value_q;

endmodule

// File: tb/tb_xsw_egress_arbiter.sv
// Directed self-checking bench for xsw_egress_arbiter.
// Inputs change 1ns after posedge; checks run 2ns after posedge.
module tb_xsw_egress_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_rdy;
    logic [63:0] addr_out;
    logic [63:0] data_out;
    logic [7:0]  rd_en;
    logic        drain_en;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_port;
    logic [7:0]  out_addr;
    logic [7:0]  out_data;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_value;
    logic        cnt_clr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xsw_egress_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .data_rdy  (data_rdy),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .rd_en     (rd_en),
        .drain_en  (drain_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value),
        .cnt_clr   (cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        data_rdy  = 8'hFF;
        addr_out  = '0;
        data_out  = '0;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        cnt_sel   = 3'd0;
        cnt_clr   = 1'b0;
        settle();
        chk("rd_en_in_reset", 64'(rd_en), 64'h00);
        tick();
        tick();
        settle();
        chk("rd_en_in_reset2", 64'(rd_en), 64'h00);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_port", 64'(out_port), 64'h0);
        chk("rst_out_addr", 64'(out_addr), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_cnt_value", 64'(cnt_value), 64'h0);

        // Single beat from port 0
        reset    = 1'b0;
        data_rdy = 8'h01;
        addr_out = 64'h0000_0000_0000_00A5;
        data_out = 64'h0000_0000_0000_003C;
        settle();
        chk("single_rd_en", 64'(rd_en), 64'h01);
        tick();
        data_rdy = 8'h00;
        settle();
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_port", 64'(out_port), 64'h0);
        chk("single_addr", 64'(out_addr), 64'hA5);
        chk("single_data", 64'(out_data), 64'h3C);
        chk("single_no_pop", 64'(rd_en), 64'h00);

        // Reset again so the pointer starts at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Full round-robin sweep
        addr_out = 64'hA7A6_A5A4_A3A2_A1A0;
        data_out = 64'h5756_5554_5352_5150;
        data_rdy = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            settle();
            chk("rr_rd_en", 64'(rd_en), 64'(8'h01 << (k % 8)));
            chk("rr_one_hot", 64'($countones(rd_en)), 64'd1);
            tick();
            chk("rr_port", 64'(out_port), 64'(k % 8));
            chk("rr_addr", 64'(out_addr), 64'(8'hA0 + (k % 8)));
            chk("rr_data", 64'(out_data), 64'(8'h50 + (k % 8)));
        end

        // Back-pressure: stage holds port 0 beat, pointer at 1
        data_rdy  = 8'h10;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_rd_en", 64'(rd_en), 64'h00);
            tick();
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_port", 64'(out_port), 64'h0);
            chk("bp_addr", 64'(out_addr), 64'hA0);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_rd_en", 64'(rd_en), 64'h10);
        tick();
        chk("bp_next_port", 64'(out_port), 64'h4);
        chk("bp_next_addr", 64'(out_addr), 64'hA4);
        data_rdy = 8'h00;
        tick();
        chk("bp_drained", 64'(out_valid), 64'h0);

        // Counters: port0 = 2, port4 = 2, port3 = 1
        cnt_sel = 3'd0;
        tick();
        chk("cnt_port0", 64'(cnt_value), 64'd2);
        cnt_sel = 3'd4;
        tick();
        chk("cnt_port4", 64'(cnt_value), 64'd2);
        cnt_sel = 3'd3;
        tick();
        chk("cnt_port3", 64'(cnt_value), 64'd1);

        // drain_en gating
        data_rdy  = 8'h80;
        out_ready = 1'b0;
        settle();
        chk("de_fill_rd_en", 64'(rd_en), 64'h80);
        tick();
        chk("de_full", 64'(out_valid), 64'h1);
        drain_en  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("de_off_rd_en", 64'(rd_en), 64'h00);
        tick();
        chk("de_off_drained", 64'(out_valid), 64'h0);
        chk("de_off_rd_en2", 64'(rd_en), 64'h00);
        drain_en = 1'b1;
        settle();
        chk("de_on_rd_en", 64'(rd_en), 64'h80);
        tick();
        chk("de_on_port", 64'(out_port), 64'h7);
        data_rdy = 8'h00;
        tick();

        // Reset while full: pointer would otherwise start at 3
        data_rdy  = 8'h04;
        out_ready = 1'b0;
        tick();
        chk("rf_full_port", 64'(out_port), 64'h2);
        data_rdy = 8'h0F;
        reset    = 1'b1;
        settle();
        chk("rf_rd_en_in_reset", 64'(rd_en), 64'h00);
        tick();
        chk("rf_valid", 64'(out_valid), 64'h0);
        chk("rf_port", 64'(out_port), 64'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("rf_first_grant", 64'(rd_en), 64'h01);
        tick();
        chk("rf_first_port", 64'(out_port), 64'h0);
        data_rdy = 8'h00;
        tick();

        // Saturation on port 2: 65534 accepted beats, then 3 more
        cnt_sel  = 3'd2;
        data_rdy = 8'h04;
        for (int k = 0; k < 65535; k++) begin
            @(posedge clk);
        end
        #1;
        data_rdy  = 8'h00;
        out_ready = 1'b0;
        tick();
        chk("sat_preload", 64'(cnt_value), 64'hFFFE);
        out_ready = 1'b1;
        data_rdy  = 8'h04;
        tick();
        tick();
        data_rdy = 8'h00;
        tick();
        chk("sat_drain_empty", 64'(out_valid), 64'h0);
        out_ready = 1'b0;
        tick();
        chk("sat_value", 64'(cnt_value), 64'hFFFF);

        // Clear with a concurrent accept
        out_ready = 1'b1;
        data_rdy  = 8'h04;
        tick();
        chk("clr_full", 64'(out_valid), 64'h1);
        data_rdy = 8'h00;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        chk("clr_value", 64'(cnt_value), 64'h0);
        tick();
        chk("clr_value_hold", 64'(cnt_value), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xsw_egress_arbiter.md
XSW_EGRESS_ARBITER -- requirements
Module: xsw_egress_arbiter

Interface
REQ-001 Parameter NPORTS, default 8: number of switch output ports, fixed 8 in this release.
REQ-002 Parameter CNT_W, default 16: width of per-port drain counters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_rdy  input  8  per-port switch output FIFO non-empty; bit i = port i.
REQ-006 addr_out  input  64  per-port head address; byte i = port i; valid while data_rdy[i]=1 (first-word-fall-through).
REQ-007 data_out  input  64  per-port head data; byte i = port i; valid while data_rdy[i]=1.
REQ-008 rd_en  output  8  per-port pop strobe to switch; at most one bit high per cycle.
REQ-009 drain_en  input  1  1 = arbitration enabled; 0 = no new pops.
REQ-010 out_valid  output  1  egress beat valid.
REQ-011 out_ready  input  1  sink accepts beat when out_valid & out_ready.
REQ-012 out_port  output  3  source port index of current beat.
REQ-013 out_addr  output  8  address byte of current beat.
REQ-014 out_data  output  8  data byte of current beat.
REQ-015 cnt_sel  input  3  port index for counter readback.
REQ-016 cnt_value  output  CNT_W  drained-beat count of port cnt_sel, registered.
REQ-017 cnt_clr  input  1  synchronous clear of all counters.

Function
REQ-018 Output stage: one register (out_port/out_addr/out_data/out_valid); FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 Stage "free" in a cycle = EMPTY, or FULL with out_ready=1.
REQ-020 Pop condition: drain_en=1, stage free, data_rdy != 0.
REQ-021 On pop, grant = first port with data_rdy set, searching circularly from rr_ptr; rd_en[grant]=1 combinationally that cycle; all other rd_en bits 0.
REQ-022 On pop, at next posedge: stage loads grant, addr_out/data_out bytes [8*grant +: 8]; state -> FULL; rr_ptr <= (grant+1) mod 8.
REQ-023 FULL with out_ready=1 and no pop: state -> EMPTY; FULL with out_ready=0: state and payload held unchanged, rd_en=0.
REQ-024 Latency: data_rdy[i] rising with stage EMPTY -> out_valid=1 next cycle; sustained throughput one beat per cycle while out_ready=1.
REQ-025 rr_ptr unchanged on cycles without a pop; wraps 7 -> 0.
REQ-026 drain_en=0 suppresses pops only; a FULL stage still drains via out_ready.
REQ-027 Counter i increments by 1 on each accepted beat (out_valid & out_ready) with out_port=i; saturates at 2^CNT_W-1.
REQ-028 cnt_clr=1 zeroes all counters; clear takes priority over a simultaneous increment.
REQ-029 cnt_value = counter[cnt_sel] registered, one-cycle latency, reflecting counter state before the current edge.
REQ-030 data_rdy bits of non-granted ports are never popped; data_rdy dropping without grant is legal and ignored.

Reset
REQ-031 reset=1 at posedge: state EMPTY, out_valid=0, out_port=0, out_addr=0, out_data=0, rr_ptr=0, all counters 0, cnt_value=0.
REQ-032 While reset=1, rd_en=8'h00 regardless of data_rdy; a beat held in the stage during reset is discarded and not counted.

Structure
REQ-033 Shared package xsw_pkg holds NPORTS, port-index width (3), byte width (8), CNT_W default and the FSM state enum.
REQ-034 One sub-module xsw_rr_arbiter: 8-bit request, 3-bit pointer in; one-hot grant, grant index, any-grant out; purely combinational.

Verification
REQ-035 data_rdy=8'h01, addr byte0=8'hA5, data byte0=8'h3C, out_ready=1 -> rd_en=8'h01 same cycle; next cycle out_valid=1, out_port=0, out_addr=8'hA5, out_data=8'h3C.
REQ-036 data_rdy=8'hFF held, out_ready=1, rr_ptr=0 -> out_port sequence 0,1,...,7,0 on consecutive cycles, exactly one rd_en bit per cycle.
REQ-037 Stage FULL, out_ready=0 for 5 cycles with data_rdy=8'h10 -> rd_en=0 and payload stable 5 cycles; out_ready=1 -> beat accepted and port 4 popped same cycle.
REQ-038 Counter port 2 preloaded to 16'hFFFE, 3 accepted beats from port 2 -> cnt_value 16'hFFFF (saturated); cnt_clr with concurrent accept -> 0.
REQ-039 reset asserted while FULL and data_rdy=8'h0F -> next cycle out_valid=0, rd_en=0, rr_ptr=0; after release first grant = port 0.
REQ-040 drain_en=0, data_rdy=8'h80, stage FULL, out_ready=1 -> beat drains, no rd_en; drain_en=1 -> port 7 popped.
